// File: rtl/cmp_arbiter_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
// Consumers use the FLAG_* indices to pick result bits out of a flag vector.
package cmp_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 4;

  localparam int FLAG_GT   = 0;
  localparam int FLAG_EQ   = 1;
  localparam int FLAG_LT   = 2;
  localparam int NUM_FLAGS = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Requester-side bus of the comparator arbiter: level requests with packed operands in,
// one-hot grant plus tagged, done-qualified result flags out.
interface cmp_arbiter_if
  import cmp_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);

  localparam int ID_W = $clog2(N_REQ);

  logic                   cmp_en;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic                   greater;
  logic                   equal;
  logic                   less;

  modport master (
    output cmp_en, req, a_in, b_in,
    input  gnt, done, done_id, greater, equal, less
  );

  modport slave (
    input  cmp_en, req, a_in, b_in,
    output gnt, done, done_id, greater, equal, less
  );

endinterface

// File: rtl/cmp_arbiter_cmp4_core.sv
// Combinational unsigned magnitude comparator; 0-cycle latency, no backpressure.
// All three outputs are forced low while en is low.
module cmp4_core
  import cmp_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = en && (a > b);
  assign eq = en && (a == b);
  assign lt = en && (a < b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin share of one comparator core; grant 1 cycle and done 2 cycles after a sampled
// request, one op per 3 cycles; requesters wait by holding req, cmp_en low blocks new grants.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  cmp_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] COMPARE = ST_COMPARE;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [1:0]           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      cur_id;
  logic [ID_W-1:0]      done_id_q;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [NUM_FLAGS-1:0] flags;

  logic                 win_vld;
  logic [ID_W-1:0]      win_id;
  logic                 hi_vld;
  logic [ID_W-1:0]      hi_id;
  logic [ID_W-1:0]      lo_id;

  logic                 core_en;
  logic                 core_gt;
  logic                 core_eq;
  logic                 core_lt;
  logic [N_REQ-1:0]     gnt_vec;

  // Masked scan: lowest request at or above rr_ptr wins, else wrap to the lowest request overall.
  always_comb begin
    win_vld = 1'b0;
    hi_vld  = 1'b0;
    hi_id   = '0;
    lo_id   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_vld = 1'b1;
        lo_id   = ID_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    win_id = hi_vld ? hi_id : lo_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      done_id_q <= '0;
      op_a      <= '0;
      op_b      <= '0;
      flags     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmp_en && win_vld) begin
            op_a   <= bus.a_in[int'(win_id)*WIDTH +: WIDTH];
            op_b   <= bus.b_in[int'(win_id)*WIDTH +: WIDTH];
            cur_id <= win_id;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          flags[FLAG_GT] <= core_gt;
          flags[FLAG_EQ] <= core_eq;
          flags[FLAG_LT] <= core_lt;
          done_id_q      <= cur_id;
          state          <= DONE;
        end
        DONE: begin
          rr_ptr <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_en = (state == COMPARE);

  cmp4_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .en(core_en),
    .a (op_a),
    .b (op_b),
    .gt(core_gt),
    .eq(core_eq),
    .lt(core_lt)
  );

  always_comb begin
    gnt_vec = '0;
    if (state == COMPARE) gnt_vec[cur_id] = 1'b1;
  end

  assign bus.gnt     = gnt_vec;
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id_q;
  assign bus.greater = flags[FLAG_GT];
  assign bus.equal   = flags[FLAG_EQ];
  assign bus.less    = flags[FLAG_LT];

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_cmp_arbiter;

  localparam int NR = 4;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cmp_arbiter_if #(.N_REQ(NR), .WIDTH(W)) bus ();

  cmp_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[id*W +: W] = a;
    bus.b_in[id*W +: W] = b;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    rst = 1'b1;
    bus.cmp_en = 1'b1;
    bus.req = 4'b1111;
    bus.a_in = '0;
    bus.b_in = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      outs = {bus.gnt, bus.done, bus.done_id, bus.greater, bus.equal, bus.less};
      checks++;
      if (outs !== 10'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0", c, outs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_done: got done=%b id=%0d expected done=1 id=0", bus.done, bus.done_id);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    set_ops(0, 4'd9, 4'd5);
    bus.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt: got gnt=%b done=%b expected gnt=0001 done=0", bus.gnt, bus.done);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id, bus.greater, bus.equal, bus.less, bus.gnt} !== {1'b1, 2'd0, 3'b100, 4'b0000}) begin
      failures++;
      $display("FAIL single_done: got done=%b id=%0d gel=%b%b%b gnt=%b expected done=1 id=0 gel=100 gnt=0000",
               bus.done, bus.done_id, bus.greater, bus.equal, bus.less, bus.gnt);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.greater, bus.equal, bus.less} !== 4'b0100) begin
      failures++;
      $display("FAIL single_hold: got done=%b gel=%b%b%b expected done=0 gel=100",
               bus.done, bus.greater, bus.equal, bus.less);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    logic [2:0] exp_fl [5];
    logic       got;
    int         gap;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_fl = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ops(0, 4'd12, 4'd12);
    set_ops(1, 4'd4,  4'd9);
    set_ops(2, 4'd5,  4'd1);
    set_ops(3, 4'd2,  4'd7);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      gap = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.done) begin
          got = 1'b1;
          gap = c;
          break;
        end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rr_timeout op %0d: got no done within 6 cycles expected done", k);
        continue;
      end
      checks++;
      if (gap !== ((k == 0) ? 1 : 2)) begin
        failures++;
        $display("FAIL rr_spacing op %0d: got gap %0d expected %0d", k, gap, (k == 0) ? 1 : 2);
      end
      checks++;
      if (bus.done_id !== exp_id[k] || {bus.greater, bus.equal, bus.less} !== exp_fl[k] || bus.gnt !== 4'b0) begin
        failures++;
        $display("FAIL rr_result op %0d: got id=%0d gel=%b%b%b gnt=%b expected id=%0d gel=%b gnt=0000",
                 k, bus.done_id, bus.greater, bus.equal, bus.less, bus.gnt, exp_id[k], exp_fl[k]);
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_enable_gating();
    int seen;
    seen = 0;
    bus.cmp_en = 1'b0;
    set_ops(2, 4'd3, 4'd3);
    bus.req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.gnt !== 4'b0 || bus.done !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL gating_blocked: got %0d active cycles expected 0", seen);
    end
    bus.cmp_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL gating_gnt: got %b expected 0100", bus.gnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id, bus.greater, bus.equal, bus.less} !== {1'b1, 2'd2, 3'b010}) begin
      failures++;
      $display("FAIL gating_done: got done=%b id=%0d gel=%b%b%b expected done=1 id=2 gel=010",
               bus.done, bus.done_id, bus.greater, bus.equal, bus.less);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_operand_capture();
    set_ops(1, 4'd15, 4'd0);
    bus.req = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL capture_gnt: got %b expected 0010", bus.gnt);
    end
    // Disturb everything mid-operation: new operand, dropped request, enable low.
    set_ops(1, 4'd0, 4'd0);
    bus.req = 4'b0000;
    bus.cmp_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id, bus.greater, bus.equal, bus.less} !== {1'b1, 2'd1, 3'b100}) begin
      failures++;
      $display("FAIL capture_done: got done=%b id=%0d gel=%b%b%b expected done=1 id=1 gel=100",
               bus.done, bus.done_id, bus.greater, bus.equal, bus.less);
    end
    bus.cmp_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [9:0] outs;
    set_ops(3, 4'd1, 4'd2);
    bus.req = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_gnt: got %b expected 1000", bus.gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {bus.gnt, bus.done, bus.done_id, bus.greater, bus.equal, bus.less};
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got %b expected 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_regrant: got gnt=%b done=%b expected gnt=1000 done=0", bus.gnt, bus.done);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id, bus.greater, bus.equal, bus.less} !== {1'b1, 2'd3, 3'b001}) begin
      failures++;
      $display("FAIL midrst_done: got done=%b id=%0d gel=%b%b%b expected done=1 id=3 gel=001",
               bus.done, bus.done_id, bus.greater, bus.equal, bus.less);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_enable_gating();
    test_operand_capture();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
